// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection controller: phase encodings,
// lamp codes and phase-sequencing helpers.
package traffic_pkg;

    typedef logic [4:0] dur_t;
    typedef logic [2:0] state_t;

    localparam state_t NS_G  = 3'd0;
    localparam state_t NS_Y  = 3'd1;
    localparam state_t AR1   = 3'd2;
    localparam state_t EW_G  = 3'd3;
    localparam state_t EW_Y  = 3'd4;
    localparam state_t AR2   = 3'd5;
    localparam state_t EMERG = 3'd6;

    localparam logic [2:0] LAMP_G = 3'b001;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b100;

    function automatic state_t next_phase(input state_t s);
        case (s)
            NS_G:    next_phase = NS_Y;
            NS_Y:    next_phase = AR1;
            AR1:     next_phase = EW_G;
            EW_G:    next_phase = EW_Y;
            EW_Y:    next_phase = AR2;
            default: next_phase = NS_G;
        endcase
    endfunction

    function automatic logic [2:0] ns_lamp(input state_t s);
        case (s)
            NS_G:    ns_lamp = LAMP_G;
            NS_Y:    ns_lamp = LAMP_Y;
            default: ns_lamp = LAMP_R;
        endcase
    endfunction

    function automatic logic [2:0] ew_lamp(input state_t s);
        case (s)
            EW_G:    ew_lamp = LAMP_G;
            EW_Y:    ew_lamp = LAMP_Y;
            default: ew_lamp = LAMP_R;
        endcase
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_DIV sys_clk cycles; clr holds
// the count at zero so timing restarts cleanly.
module tick_gen #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_p,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge sys_clk or posedge sys_rst_p) begin
        if (sys_rst_p) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/intersection_ctrl.sv
// Two-way intersection controller: fixed phase cycle with all-red clearance,
// latched pedestrian requests served on green entry, and an emergency override.
module intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int CLK_DIV  = 50_000_000,
    parameter int GREEN_T  = 10,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst_p,
    input  logic       ped_req_ns,
    input  logic       ped_req_ew,
    input  logic       emerg,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk_ns,
    output logic       walk_ew,
    output logic       ped_ack_ns,
    output logic       ped_ack_ew,
    output dur_t       remain_t
);

    state_t state;
    state_t state_nx;
    dur_t   remain_nx;
    logic   pend_ns;
    logic   pend_ew;
    logic   tick;
    logic   clr;
    logic   enter_ns_g;
    logic   enter_ew_g;

    function automatic dur_t phase_dur(input state_t s);
        case (s)
            NS_G, EW_G: phase_dur = dur_t'(GREEN_T);
            NS_Y, EW_Y: phase_dur = dur_t'(YELLOW_T);
            default:    phase_dur = dur_t'(ALLRED_T);
        endcase
    endfunction

    // Prescaler is frozen during emergency and on any illegal encoding.
    assign clr = emerg || (state >= EMERG);

    tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .sys_clk  (sys_clk),
        .sys_rst_p(sys_rst_p),
        .clr      (clr),
        .tick     (tick)
    );

    always_comb begin
        state_nx  = state;
        remain_nx = remain_t;
        case (state)
            NS_G, NS_Y, AR1, EW_G, EW_Y, AR2: begin
                if (emerg) begin
                    state_nx  = EMERG;
                    remain_nx = '0;
                end else if (tick) begin
                    if (remain_t > 5'd1) begin
                        remain_nx = remain_t - 5'd1;
                    end else begin
                        state_nx  = next_phase(state);
                        remain_nx = phase_dur(state_nx);
                    end
                end
            end
            EMERG: begin
                if (emerg) begin
                    remain_nx = '0;
                end else begin
                    state_nx  = AR2;
                    remain_nx = dur_t'(ALLRED_T);
                end
            end
            default: begin
                state_nx  = AR2;
                remain_nx = dur_t'(ALLRED_T);
            end
        endcase
    end

    assign enter_ns_g = (state_nx == NS_G) && (state != NS_G);
    assign enter_ew_g = (state_nx == EW_G) && (state != EW_G);

    // Outputs derive from the next state so they are valid in a phase's first cycle.
    always_ff @(posedge sys_clk or posedge sys_rst_p) begin
        if (sys_rst_p) begin
            state      <= AR2;
            remain_t   <= dur_t'(ALLRED_T);
            ns_light   <= LAMP_R;
            ew_light   <= LAMP_R;
            walk_ns    <= 1'b0;
            walk_ew    <= 1'b0;
            ped_ack_ns <= 1'b0;
            ped_ack_ew <= 1'b0;
            pend_ns    <= 1'b0;
            pend_ew    <= 1'b0;
        end else begin
            state      <= state_nx;
            remain_t   <= remain_nx;
            ns_light   <= ns_lamp(state_nx);
            ew_light   <= ew_lamp(state_nx);
            pend_ns    <= enter_ns_g ? ped_req_ns : (pend_ns | ped_req_ns);
            pend_ew    <= enter_ew_g ? ped_req_ew : (pend_ew | ped_req_ew);
            ped_ack_ns <= enter_ns_g && pend_ns;
            ped_ack_ew <= enter_ew_g && pend_ew;
            walk_ns    <= enter_ns_g ? pend_ns : (walk_ns && state_nx == NS_G);
            walk_ew    <= enter_ew_g ? pend_ew : (walk_ew && state_nx == EW_G);
        end
    end

endmodule

// File: doc/intersection_ctrl.md
INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- CLK_DIV  50_000_000  sys_clk cycles per 1 s tick; legal range >= 2.
- GREEN_T  10  green duration in ticks.
- YELLOW_T  3  yellow duration in ticks.
- ALLRED_T  2  all-red clearance duration in ticks.
- All durations are legal in the range 1..31.
REQ-002 Ports, one per line: name  direction  width  meaning.
- sys_clk  in  1  system clock; the only clock.
- sys_rst_p  in  1  reset, asynchronous, active-high.
- ped_req_ns  in  1  pedestrian request to walk alongside north-south traffic; synchronous to sys_clk; any-length pulse.
- ped_req_ew  in  1  pedestrian request to walk alongside east-west traffic; same rules as ped_req_ns.
- emerg  in  1  emergency override, level-sensitive, synchronous to sys_clk.
- ns_light  out  3  north-south lamp, one-hot {R,Y,G}: 001 green, 010 yellow, 100 red.
- ew_light  out  3  east-west lamp; same encoding as ns_light.
- walk_ns  out  1  north-south walk signal.
- walk_ew  out  1  east-west walk signal.
- ped_ack_ns  out  1  one-cycle pulse when a pending north-south request is served.
- ped_ack_ew  out  1  one-cycle pulse when a pending east-west request is served.
- remain_t  out  5  ticks left in the current phase.

Function
REQ-003 Tick generation: a prescaler counts 0..CLK_DIV-1 and produces tick for exactly 1 cycle when the count equals CLK_DIV-1, then wraps to 0.
REQ-004 States: NS_G, NS_Y, AR1, EW_G, EW_Y, AR2, EMERG. Normal cycle is NS_G->NS_Y->AR1->EW_G->EW_Y->AR2->NS_G.
REQ-005 Phase timing:
- On a tick cycle with remain_t > 1: remain_t decrements by 1.
- On a tick cycle with remain_t == 1: the state advances and remain_t loads the new phase duration, both on the same clock edge.
REQ-006 Lamp outputs are registered and valid in the first cycle of each state.
- NS_G: ns 001, ew 100.
- NS_Y: ns 010, ew 100.
- EW_G: ns 100, ew 001.
- EW_Y: ns 100, ew 010.
- AR1, AR2, EMERG: both 100.
REQ-007 Green exclusivity: ns_light and ew_light are never non-red in the same cycle.
REQ-008 Pedestrian pending latch:
- ped_req_x sets pend_x.
- pend_x is cleared only on entry to X_G.
- A request asserted in the same cycle as the X_G entry edge stays pending for the next X_G.
REQ-009 Pedestrian service on entry to X_G with pend_x set:
- ped_ack_x pulses for exactly 1 cycle, coincident with the first X_G cycle.
- walk_x is high for every X_G cycle and low in all other states.
REQ-010 Emergency entry:
- emerg high in any non-EMERG state moves the block to EMERG on the next clock edge, regardless of tick.
- In EMERG: walk_ns and walk_ew = 0; remain_t = 0; the prescaler is held at 0.
- pend_ns and pend_ew are preserved.
REQ-011 Emergency exit: the first cycle emerg is low in EMERG moves the block to AR2 with remain_t = ALLRED_T and the prescaler restarted from 0.
REQ-012 Precedence: emerg outranks a simultaneous tick or phase expiry. A ped_req in the same cycle as emerg is still latched.
REQ-013 Illegal state encodings recover to AR2 with remain_t = ALLRED_T on the next clock edge.

Reset
REQ-014 While sys_rst_p is high, asynchronously and independent of sys_clk:
- state = AR2; remain_t = ALLRED_T.
- ns_light = ew_light = 100.
- walk_ns, walk_ew, ped_ack_ns, ped_ack_ew = 0.
- pend_ns, pend_ew = 0; prescaler = 0.
REQ-015 After sys_rst_p deasserts, the first tick is CLK_DIV cycles later. The first green phase is NS_G, reached ALLRED_T ticks after reset release.
REQ-016 Reset asserted mid-phase or in EMERG discards all timing and pending requests.

Structure
REQ-017 The shared package traffic_pkg holds:
- the state enumeration;
- the lamp code constants LAMP_G, LAMP_Y, LAMP_R;
- the 5-bit duration type.
REQ-018 The prescaler is a separate sub-module, tick_gen, with ports: sys_clk, sys_rst_p, clr, tick. intersection_ctrl instantiates it once.
REQ-019 The FSM, pending latches and output registers reside in intersection_ctrl. The estimated implementation size is 150-300 RTL lines in total.

Verification
REQ-020 The bench uses CLK_DIV=4, GREEN_T=3, YELLOW_T=2, ALLRED_T=1, and covers the following directed scenarios.
- Reset release, run one cycle -> AR2 (both 100) for 4 cycles, then NS_G with remain_t=3 and ns=001; full cycle period 48 sys_clk cycles; ew=001 is never seen while ns!=100.
- ped_req_ew pulsed for 1 cycle during NS_G -> at EW_G entry ped_ack_ew=1 for one cycle and walk_ew=1 for exactly 12 cycles; the following EW_G has walk_ew=0.
- ped_req_ns asserted exactly on the NS_G entry edge -> no ack this phase; ack and walk_ns occur on the next NS_G.
- emerg raised mid EW_G with remain_t=2 -> next edge both lamps 100, walk 0, remain_t=0; emerg held for 10 cycles then dropped -> AR2 with remain_t=1, then NS_G 4 cycles later.
- emerg asserted in the same cycle as a tick with remain_t==1 in NS_Y -> EMERG entered, not AR1.
- sys_rst_p pulsed mid NS_Y with pend_ew=1 -> immediate AR2 outputs; pend_ew is cleared, so no ack at the next EW_G.
